// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the RV32I load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN enables misaligned-access trapping.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Byte accesses never trap; 011/110/111 decode as word.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic r;
        case (f3[1:0])
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            default: r = (a != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction.
// Purely combinational; low address bits beyond the access size are ignored.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic        is_byte;
    logic        is_half;
    logic        uns;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign is_byte = (funct3[1:0] == F3_LB[1:0]);
    assign is_half = (funct3[1:0] == F3_LH[1:0]);
    assign uns     = funct3[2];
    assign lane_b  = rdata[{addr, 3'b000} +: 8];
    assign lane_h  = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        unique case (1'b1)
            is_byte: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = uns ? {24'b0, lane_b}
                                : {{24{lane_b[7]}}, lane_b};
            end
            is_half: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = uns ? {16'b0, lane_h}
                                : {{16{lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: valid/ack data-memory handshake with PC stall.
// Build option: LSU_MISALIGN_TRAP_EN adds the misaligned output and trap path.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    lsu_state_e        state;
    lsu_state_e        state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_a;
    logic [31:0]       wdata_a;
    logic [31:0]       rdata_a;
    logic              trap;
    logic              take;

    assign take = (state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = is_misaligned(req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (take) begin
            mis_q <= trap;
        end
    end

    assign misaligned = (state == DONE) && mis_q;
`else
    assign trap = 1'b0;
`endif

    lsu_align u_align (
        .funct3    (f3_q),
        .addr      (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (be_a),
        .wdata_rep (wdata_a),
        .rdata_ext (rdata_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = trap ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            load_data <= 32'h0;
        end else begin
            if (take) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state == BUSY) && mem_ack && !we_q) begin
                load_data <= rdata_a;
            end
        end
    end

    // Memory-side outputs are zero outside BUSY so idle buses stay quiet.
    always_comb begin
        stall      = 1'b0;
        load_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        mem_be     = 4'b0000;
        unique case (state)
            IDLE: stall = req_valid;
            BUSY: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = wdata_a;
                mem_be    = be_a;
            end
            DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                load_valid = !we_q && !mis_q;
`else
                load_valid = !we_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, queued expectations,
// and a negedge monitor that checks every memory request and load pulse.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] load_q[$];
    int          checks = 0;
    int          failures = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h required none",
                             mem_addr);
                end else begin
                    check32("mem_we", mem_we, mem_q[0].we);
                    check32("mem_addr", mem_addr, mem_q[0].addr);
                    check32("mem_be", mem_be, mem_q[0].be);
                    if (mem_q[0].we) check32("mem_wdata", mem_wdata, mem_q[0].wdata);
                    if (mem_ack) void'(mem_q.pop_front());
                end
            end
            if (load_valid) begin
                if (load_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load_valid: got data 0x%08h required none",
                             load_data);
                end else begin
                    check32("load_data", load_data, load_q.pop_front());
                end
            end
        end
    end

    task automatic access(
        input string       name,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          ack_after,
        input int          exp_stalls,
        input logic        exp_mis,
        input logic [31:0] eaddr,
        input logic [3:0]  ebe,
        input logic [31:0] ewd,
        input logic [31:0] eld
    );
        int   stalls = 0;
        int   nb = 0;
        bit   done = 0;
        mem_t e;
        if (!exp_mis) begin
            e.we = we;
            e.addr = eaddr;
            e.be = ebe;
            e.wdata = ewd;
            mem_q.push_back(e);
            if (!we) load_q.push_back(eld);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_ack    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0BAD0BAD;
            end
            #1;
            if (stall) begin
                stalls++;
            end else begin
                done = 1;
                check32({name, "_load_valid"}, load_valid, !we && !exp_mis);
`ifdef LSU_MISALIGN_TRAP_EN
                check32({name, "_misaligned"}, misaligned, exp_mis);
`endif
            end
            if (mem_req) begin
                nb++;
                if (nb == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got stall still high required DONE", name);
        end else begin
            check32({name, "_stalls"}, stalls, exp_stalls);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        mem_t e;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        check32("rst_stall", stall, 1'b0);
        check32("rst_mem_req", mem_req, 1'b0);
        check32("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_mem_be", mem_be, 4'h0);
        check32("rst_load_valid", load_valid, 1'b0);
        check32("rst_load_data", load_data, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check32("rst_misaligned", misaligned, 1'b0);
`endif
        req_valid = 1'b1;
        #1;
        check32("rst_stall_follows_req", stall, 1'b1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        access("sw",  1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 3, 0,
               32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("sb",  1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 2, 0,
               32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access("sh",  1, 3'b001, 32'h302, 32'h00001234, 32'h0, 1, 2, 0,
               32'h300, 4'b1100, 32'h12341234, 32'h0);
        access("lb",  0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 1, 2, 0,
               32'h100, 4'b0100, 32'h0, 32'hFFFFFFF0);
        access("lbu", 0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 1, 2, 0,
               32'h100, 4'b0100, 32'h0, 32'h000000F0);
        access("lb1", 0, 3'b000, 32'h001, 32'h0, 32'h12F03456, 1, 2, 0,
               32'h000, 4'b0010, 32'h0, 32'h00000034);
        access("lh",  0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 1, 2, 0,
               32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
        access("lhu", 0, 3'b101, 32'h202, 32'h0, 32'h80017FFF, 2, 3, 0,
               32'h200, 4'b1100, 32'h0, 32'h00008001);
`ifndef LSU_MISALIGN_TRAP_EN
        access("lh_odd", 0, 3'b001, 32'h201, 32'h0, 32'h80017FFF, 1, 2, 0,
               32'h200, 4'b0011, 32'h0, 32'h00007FFF);
        access("lw_odd", 0, 3'b010, 32'h107, 32'h0, 32'h01020304, 1, 2, 0,
               32'h104, 4'b1111, 32'h0, 32'h01020304);
`endif
        access("lw",  0, 3'b010, 32'h204, 32'h0, 32'h89ABCDEF, 3, 4, 0,
               32'h204, 4'b1111, 32'h0, 32'h89ABCDEF);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_trap", 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1, 1,
               32'h0, 4'h0, 32'h0, 32'h0);
        check32("trap_keeps_load_data", load_data, 32'h89ABCDEF);
        access("lh_trap", 0, 3'b001, 32'h203, 32'h0, 32'h0, 1, 1, 1,
               32'h0, 4'h0, 32'h0, 32'h0);
`endif
        access("sw2", 1, 3'b010, 32'h500, 32'h13579BDF, 32'h0, 1, 2, 0,
               32'h500, 4'b1111, 32'h13579BDF, 32'h0);
        check32("store_keeps_load_data", load_data, 32'h89ABCDEF);

        // Stray ack while idle must do nothing.
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        #1;
        check32("idle_ack_mem_req", mem_req, 1'b0);
        @(posedge clk);
        #2;
        mem_ack = 1'b0;
        check32("idle_ack_stall", stall, 1'b0);
        check32("idle_ack_load_valid", load_valid, 1'b0);
        check32("idle_ack_load_data", load_data, 32'h89ABCDEF);

        // Reset in the middle of an outstanding load.
        e.we = 1'b0;
        e.addr = 32'h400;
        e.be = 4'b1111;
        e.wdata = 32'h0;
        mem_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        @(posedge clk);
        #2;
        check32("busy_before_reset", mem_req, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check32("reset_drops_mem_req", mem_req, 1'b0);
        check32("reset_clears_load_data", load_data, 32'h0);
        check32("reset_stall_is_req_valid", stall, 1'b1);
        mem_q.delete();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check32("post_reset_stall", stall, 1'b0);
        check32("post_reset_mem_req", mem_req, 1'b0);
        check32("post_reset_load_data", load_data, 32'h0);
        access("lbu_after_rst", 0, 3'b100, 32'h401, 32'h0, 32'h0000AA00, 1, 2, 0,
               32'h400, 4'b0010, 32'h0, 32'h000000AA);

        repeat (3) @(posedge clk);
        #2;
        check32("mem_q_drained", mem_q.size(), 0);
        check32("load_q_drained", load_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the single-cycle RV32I core. It takes one load or store per instruction from the execute stage and runs a valid/ack handshake with data memory. It stalls the PC while the access is outstanding. Loads come back byte-lane-aligned and sign- or zero-extended, and feed the load-data input of the writeback select mux.

## Interface
- `ADDR_W`, 32: address width; data width is fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: current instruction is a load/store; held until `stall` drops.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size/sign field.
- `req_addr` in ADDR_W: byte address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: hold PC and regfile write.
- `load_data` out 32: extended load result to writeback mux.
- `load_valid` out 1: one-cycle pulse, `load_data` freshly updated.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: word-aligned address (`[1:0]` = 0).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.
- `misaligned` out 1: present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- **IDLE**
  - When `req_valid`=1, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are driven from the latched values and held stable.
  - When `mem_ack`=1, capture `mem_rdata` and go to DONE.
- **DONE**
  - `stall`=0.
  - After a load, `load_valid`=1.
  - `req_valid` is ignored, because it still belongs to the same instruction.
  - Always return to IDLE.
- `stall` = (IDLE & `req_valid`) | BUSY. This is combinational, so the PC is held from the request cycle onward.
- **Byte enables**
  - Byte access (funct3[1:0]=00): `mem_be` = `4'b0001 << addr[1:0]`.
  - Half access (01): `mem_be` = addr[1] ? `1100` : `0011`.
  - Word access (10): `mem_be` = `1111`.
  - funct3 values 011, 110 and 111 are treated as word.
  - Loads drive the same `mem_be` pattern as stores.
- **Store data**
  - SB replicates the byte 4×.
  - SH replicates the halfword 2×.
  - SW passes the data through.
- **Load extraction**
  - Select the lane using addr[1:0].
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- `load_data` is a register. It is updated only on `mem_ack` of a load, and stores leave it unchanged.
- Misaligned addresses without the macro: the low address bits are ignored. Half accesses use addr[1] only; word accesses ignore addr[1:0].

## Timing
- Reset values: FSM in IDLE, and `mem_req`, `mem_we`, `load_valid` and `misaligned` all 0. `mem_addr`, `mem_wdata`, `mem_be` and `load_data` are all 0. `stall` = `req_valid`.
- Latency:
  - Request seen in cycle 0. `mem_req` is high from cycle 1.
  - Ack arrives in cycle k ≥ 1. DONE is cycle k+1.
  - The minimum access therefore takes 3 cycles, with `stall` high for cycles 0..k.
- `mem_ack` while not in BUSY is ignored.
- `mem_ack` in the first BUSY cycle is legal.
- An unbounded ack wait is legal; `stall` stays high.
- Reset asserted mid-access: `mem_req` drops asynchronously and the FSM returns to IDLE. Memory must tolerate the abandoned request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - The `misaligned` port exists.
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is flagged. It goes IDLE→DONE without asserting `mem_req`.
  - In that DONE cycle, `misaligned`=1 for one cycle, `load_valid`=0, and `load_data` is unchanged.
- Undefined: no `misaligned` port, and the low bits are ignored as described under Operation.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010);
  - the state enum (IDLE, BUSY, DONE).
- Sub-module `lsu_align` is purely combinational. Given funct3, addr[1:0], wdata and rdata, it produces `mem_be`, replicated wdata and extended load data. It is instantiated once.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, ack after 2 BUSY cycles:
  - `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF;
  - `stall` high for 3 cycles;
  - `load_valid` never asserted.
- SB to 0x103 with data 0x000000A5: `mem_be`=1000 and `mem_wdata`=0xA5A5A5A5.
- LB from 0x102 with rdata 0x12F03456, ack on the first BUSY cycle:
  - `load_data`=0xFFFFFFF0 in the DONE cycle, with `load_valid` pulsing once;
  - LBU of the same address gives 0x000000F0.
- LH from 0x202 with rdata 0x80017FFF: `load_data`=0xFFFF8001; LHU of the same address gives 0x00008001.
- `rst_n` pulled low while in BUSY: `mem_req` goes to 0 at once, and the FSM is in IDLE after release with `load_data` reset to 0.
- With `LSU_MISALIGN_TRAP_EN` defined, LW from 0x101:
  - `mem_req` is never asserted;
  - `misaligned` is 1 in the cycle after the request;
  - `load_valid`=0 throughout.
